rx_timer: RTL and testbench

- Receiver-side (slave end) LP/turnaround timer for the C-PHY link; companion to the master TX timer on the opposite end of the same LP protocol.
- Driven by the RX LP/turnaround FSM: FSM raises TimerEn with a seed selecting an interval. The block reports minimum-reached (window open) and maximum-reached (timeout), and holds an expired state until the FSM drops the enable.
- Covers termination enable, HS-settle window, TA-Sure window and TA-Get drive time.

---
 rtl/rx_timer.sv | 147 ++++++++++++++
 tb/tb_rx_timer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/rx_timer.sv
// Receiver-side LP/turnaround interval timer: reports window minimum, timeout and expiry.
// Optional early-exit error pulse (ErrEarly) when RX_TIMER_ERR_EN is defined.
module rx_timer #(
  parameter int CNT_W           = 16,
  parameter int T_TERM_EN       = 11,
  parameter int T_HS_SETTLE_MIN = 26,
  parameter int T_HS_SETTLE_MAX = 43,
  parameter int T_TA_SURE_MIN   = 14,
  parameter int T_TA_SURE_MAX   = 29,
  parameter int T_TA_GET        = 74
) (
  input  logic       clk,
  input  logic       RstN,
  input  logic       TimerEn,
  input  logic [1:0] TimerSeed,
  output logic       Timeout,
  output logic       MinReached,
  output logic       Expired,
  output logic       Busy
`ifdef RX_TIMER_ERR_EN
  ,
  output logic       ErrEarly
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

  function automatic logic [CNT_W-1:0] seed_min(input logic [1:0] s);
    case (s)
      2'd0:    seed_min = CNT_W'(T_TERM_EN);
      2'd1:    seed_min = CNT_W'(T_HS_SETTLE_MIN);
      2'd2:    seed_min = CNT_W'(T_TA_SURE_MIN);
      default: seed_min = CNT_W'(T_TA_GET);
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] seed_max(input logic [1:0] s);
    case (s)
      2'd0:    seed_max = CNT_W'(T_TERM_EN);
      2'd1:    seed_max = CNT_W'(T_HS_SETTLE_MAX);
      2'd2:    seed_max = CNT_W'(T_TA_SURE_MAX);
      default: seed_max = CNT_W'(T_TA_GET);
    endcase
  endfunction

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       seed_q, seed_n;
  logic             to_n, mr_n, ex_n, bz_n;
  logic [CNT_W-1:0] mn_live, mx_live, mn_q, mx_q;

  assign mn_live = seed_min(TimerSeed);
  assign mx_live = seed_max(TimerSeed);
  assign mn_q    = seed_min(seed_q);
  assign mx_q    = seed_max(seed_q);

`ifdef RX_TIMER_ERR_EN
  logic err_n;
  // Window seeds only: line left the state before the minimum was honoured.
  assign err_n = !TimerEn && (state == RUN) && !MinReached &&
                 ((seed_q == 2'd1) || (seed_q == 2'd2));
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    seed_n  = seed_q;
    to_n    = 1'b0;
    mr_n    = MinReached;
    ex_n    = Expired;
    bz_n    = Busy;
    if (!TimerEn) begin
      state_n = IDLE;
      cnt_n   = ONE;
      mr_n    = 1'b0;
      ex_n    = 1'b0;
      bz_n    = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // First enabled edge compares count 1 against the live seed.
          seed_n = TimerSeed;
          if (ONE >= mx_live) begin
            to_n    = 1'b1;
            mr_n    = 1'b1;
            ex_n    = 1'b1;
            bz_n    = 1'b0;
            state_n = EXPIRED;
          end else begin
            cnt_n   = TWO;
            bz_n    = 1'b1;
            mr_n    = (ONE >= mn_live);
            state_n = RUN;
          end
        end
        RUN: begin
          if (cnt >= mn_q) mr_n = 1'b1;
          if (cnt >= mx_q) begin
            to_n    = 1'b1;
            ex_n    = 1'b1;
            bz_n    = 1'b0;
            state_n = EXPIRED;
          end else begin
            cnt_n = cnt + ONE;
          end
        end
        EXPIRED: begin
          mr_n = 1'b1;
          ex_n = 1'b1;
          bz_n = 1'b0;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge RstN) begin
    if (!RstN) begin
      state      <= IDLE;
      cnt        <= ONE;
      seed_q     <= 2'd0;
      Timeout    <= 1'b0;
      MinReached <= 1'b0;
      Expired    <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      seed_q     <= seed_n;
      Timeout    <= to_n;
      MinReached <= mr_n;
      Expired    <= ex_n;
      Busy       <= bz_n;
    end
  end

`ifdef RX_TIMER_ERR_EN
  always_ff @(posedge clk or negedge RstN) begin
    if (!RstN) ErrEarly <= 1'b0;
    else       ErrEarly <= err_n;
  end
`endif

endmodule

// File: tb/tb_rx_timer.sv
// Scoreboard bench for rx_timer: default instance plus a T_TERM_EN=1 instance,
// checked every cycle against an interval model driven by consecutive enabled-edge count.
module tb_rx_timer;

  logic       clk = 1'b0;
  logic       RstN;
  logic       TimerEn;
  logic [1:0] TimerSeed;
  logic       to_a, mr_a, ex_a, bz_a, er_a;
  logic       to_b, mr_b, ex_b, bz_b, er_b;

  always #5 clk = ~clk;

  rx_timer u_a (
    .clk(clk), .RstN(RstN), .TimerEn(TimerEn), .TimerSeed(TimerSeed),
    .Timeout(to_a), .MinReached(mr_a), .Expired(ex_a), .Busy(bz_a)
`ifdef RX_TIMER_ERR_EN
    , .ErrEarly(er_a)
`endif
  );

  rx_timer #(.T_TERM_EN(1)) u_b (
    .clk(clk), .RstN(RstN), .TimerEn(TimerEn), .TimerSeed(TimerSeed),
    .Timeout(to_b), .MinReached(mr_b), .Expired(ex_b), .Busy(bz_b)
`ifdef RX_TIMER_ERR_EN
    , .ErrEarly(er_b)
`endif
  );

`ifndef RX_TIMER_ERR_EN
  assign er_a = 1'b0;
  assign er_b = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  logic [4:0] qa[$];
  logic [4:0] qb[$];
  int k = 0;            // consecutive enabled edges seen so far
  logic [1:0] lseed = 2'd0;

  function automatic int tmin(input logic [1:0] s, input int term);
    case (s)
      2'd0: return term;
      2'd1: return 26;
      2'd2: return 14;
      default: return 74;
    endcase
  endfunction

  function automatic int tmax(input logic [1:0] s, input int term);
    case (s)
      2'd0: return term;
      2'd1: return 43;
      2'd2: return 29;
      default: return 74;
    endcase
  endfunction

  // {Timeout, MinReached, Expired, Busy, ErrEarly}
  function automatic logic [4:0] expv(input int kk, input logic [1:0] s, input int term, input logic err);
    int mn, mx;
    mn = tmin(s, term);
    mx = tmax(s, term);
    if (kk == 0) return {4'b0000, err};
    return {kk == mx, kk >= mn, kk >= mx, kk < mx, 1'b0};
  endfunction

  task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got={to,mr,ex,bz,err}=%b expected=%b", name, $time, got, exp);
    end
  endtask

  task automatic step(input logic en, input logic [1:0] s);
    logic err;
    TimerEn   = en;
    TimerSeed = s;
    @(posedge clk);
    #1;
`ifdef RX_TIMER_ERR_EN
    err = !en && (k >= 1) && (k < tmin(lseed, 11)) && (lseed == 2'd1 || lseed == 2'd2);
`else
    err = 1'b0;
`endif
    if (en) begin
      if (k == 0) lseed = s;
      if (k < 200) k++;
    end else begin
      k = 0;
    end
    qa.push_back(expv(k, lseed, 11, err));
    qb.push_back(expv(k, lseed, 1, err));
  endtask

  always @(negedge clk) begin
    if (RstN) begin
      if (qa.size() > 0) check("out_default", {to_a, mr_a, ex_a, bz_a, er_a}, qa.pop_front());
      if (qb.size() > 0) check("out_term1", {to_b, mr_b, ex_b, bz_b, er_b}, qb.pop_front());
    end
  end

  initial begin
    int len, lo;
    logic [1:0] s;
    RstN = 1'b0; TimerEn = 1'b0; TimerSeed = 2'd0;
    #12;
    check("reset_a", {to_a, mr_a, ex_a, bz_a, er_a}, 5'b0);
    check("reset_b", {to_b, mr_b, ex_b, bz_b, er_b}, 5'b0);
    @(negedge clk); #1 RstN = 1'b1;

    // Seed 0 held 20 cycles, then released
    repeat (20) step(1'b1, 2'd0);
    repeat (2)  step(1'b0, 2'd0);
    // Seed 1 with a seed toggle at k = 10
    for (int i = 1; i <= 60; i++) step(1'b1, (i >= 10) ? 2'd3 : 2'd1);
    step(1'b0, 2'd1);
    // Seed 2 dropped at k = 20, then at k = 10 (early exit)
    repeat (20) step(1'b1, 2'd2);
    repeat (2)  step(1'b0, 2'd2);
    repeat (10) step(1'b1, 2'd2);
    repeat (2)  step(1'b0, 2'd2);
    // Seed 1 dropped early as well
    repeat (5)  step(1'b1, 2'd1);
    repeat (2)  step(1'b0, 2'd0);
    // Back-to-back: seed 0, one low cycle, seed 3
    repeat (15) step(1'b1, 2'd0);
    step(1'b0, 2'd0);
    repeat (80) step(1'b1, 2'd3);
    step(1'b0, 2'd0);

    // Reset asserted mid-run at k = 30, TimerEn held high through release
    repeat (30) step(1'b1, 2'd3);
    @(negedge clk); #1 RstN = 1'b0;
    #1;
    check("async_reset_a", {to_a, mr_a, ex_a, bz_a, er_a}, 5'b0);
    check("async_reset_b", {to_b, mr_b, ex_b, bz_b, er_b}, 5'b0);
    k = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1 RstN = 1'b1;
    repeat (80) step(1'b1, 2'd3);
    step(1'b0, 2'd0);

    // Randomized intervals with seed noise during runs
    for (int seg = 0; seg < 40; seg++) begin
      s   = 2'($urandom_range(0, 3));
      len = $urandom_range(1, 90);
      lo  = $urandom_range(1, 3);
      for (int i = 0; i < len; i++) begin
        step(1'b1, s);
        if ($urandom_range(0, 7) == 0) s = 2'($urandom_range(0, 3));
      end
      for (int i = 0; i < lo; i++) step(1'b0, 2'($urandom_range(0, 3)));
    end

    @(negedge clk);
    #1;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain remaining=%0d/%0d expected=0", qa.size(), qb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
